// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides: add/sub/inc/dec, logic ops,
// and shifts that run either one bit per cycle or as a single-cycle barrel.
module alu_seq #(
    parameter int unsigned WIDTH              = 8,
    parameter int unsigned SINGLE_CYCLE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             z,
    output logic             cout,
    output logic             n,
    output logic             v
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One shift step; returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       sub,
        input logic             right,
        input logic             fill_in
    );
        logic fill;
        if (!right) begin
            unique case (sub)
                2'b01:   fill = fill_in;
                2'b10:   fill = x[WIDTH-1];
                default: fill = 1'b0;
            endcase
            return {x[WIDTH-1], x[WIDTH-2:0], fill};
        end
        unique case (sub)
            2'b01:   fill = x[WIDTH-1];
            2'b10:   fill = x[0];
            2'b11:   fill = fill_in;
            default: fill = 1'b0;
        endcase
        return {x[0], fill, x[WIDTH-1:1]};
    endfunction

    // Amounts past WIDTH saturate for fills and wrap for rotates (non-power-of-two widths only).
    function automatic logic [SHW-1:0] eff_amt(input logic [SHW-1:0] raw, input logic rot);
        if (32'(raw) >= WIDTH) begin
            return rot ? SHW'(32'(raw) - WIDTH) : SHW'(WIDTH);
        end
        return raw;
    endfunction

    function automatic logic [WIDTH:0] barrel(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       sub,
        input logic             right,
        input logic             fill_in,
        input logic [SHW-1:0]   amt
    );
        logic [WIDTH:0] acc;
        acc = {1'b0, x};
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(amt)) begin
                acc = shift_step(acc[WIDTH-1:0], sub, right, fill_in);
            end
        end
        return acc;
    endfunction

    // Returns {v, cout, sum}; every arithmetic op is a + addend + carry.
    function automatic logic [WIDTH+1:0] arith(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c,
        input logic [1:0]       sub
    );
        logic [WIDTH-1:0] addend;
        logic             cy;
        logic [WIDTH:0]   sum;
        logic             ovf;
        unique case (sub)
            2'b00:   begin addend = y;        cy = c;    end
            2'b01:   begin addend = ~y;       cy = 1'b1; end
            2'b10:   begin addend = '0;       cy = 1'b1; end
            default: begin addend = '1;       cy = 1'b0; end
        endcase
        sum = {1'b0, x} + {1'b0, addend} + (WIDTH+1)'(cy);
        ovf = (x[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        return {ovf, sum};
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             z_q, z_d;
    logic             cout_q, cout_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    logic [WIDTH+1:0] arith_c;
    logic [WIDTH:0]   barrel_c;
    logic [SHW-1:0]   amt_c;
    logic [WIDTH-1:0] res_val_c;
    logic             res_cout_c;
    logic             res_v_c;
    logic [WIDTH:0]   step_c;

    // Single-cycle result straight from the input operands.
    always_comb begin
        res_val_c  = '0;
        res_cout_c = 1'b0;
        res_v_c    = 1'b0;
        amt_c      = eff_amt(b[SHW-1:0], s[1:0] == 2'b10);
        arith_c    = arith(a, b, cin, s[1:0]);
        barrel_c   = barrel(a, s[1:0], s[2], cin, amt_c);
        unique case (s[3:2])
            2'b00: {res_v_c, res_cout_c, res_val_c} = arith_c;
            2'b01: begin
                unique case (s[1:0])
                    2'b00:   res_val_c = a & b;
                    2'b01:   res_val_c = a | b;
                    2'b10:   res_val_c = a ^ b;
                    default: res_val_c = ~a;
                endcase
            end
            default: {res_cout_c, res_val_c} = barrel_c;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fill_d      = fill_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        z_d         = z_q;
        cout_d      = cout_q;
        n_d         = n_q;
        v_d         = v_q;
        step_c      = shift_step(work_q, op_q[1:0], op_q[2], fill_q);
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d   = s[2:0];
                    fill_d = cin;
                    if (!s[3] || (amt_c == '0) || (SINGLE_CYCLE_SHIFT != 0)) begin
                        d_d         = res_val_c;
                        z_d         = (res_val_c == '0);
                        cout_d      = res_cout_c;
                        n_d         = res_val_c[WIDTH-1];
                        v_d         = res_v_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        work_d  = a;
                        cnt_d   = amt_c;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                work_d = step_c[WIDTH-1:0];
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    d_d         = step_c[WIDTH-1:0];
                    z_d         = (step_c[WIDTH-1:0] == '0);
                    cout_d      = step_c[WIDTH];
                    n_d         = step_c[WIDTH-1];
                    v_d         = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            fill_q      <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            z_q         <= 1'b0;
            cout_q      <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            z_q         <= z_d;
            cout_q      <= cout_d;
            n_q         <= n_d;
            v_q         <= v_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign z         = z_q;
    assign cout      = cout_q;
    assign n         = n_q;
    assign v         = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a multi-cycle-shift instance and a barrel-shift instance.
module tb_alu_seq;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       in_valid0, in_valid1, out_ready0, out_ready1;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] d0, d1;
    logic       z0, c0, n0, v0, z1, c1, n1, v1;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    alu_seq #(.WIDTH(8), .SINGLE_CYCLE_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .cin(cin), .s(s), .out_valid(out_valid0), .out_ready(out_ready0),
        .d(d0), .z(z0), .cout(c0), .n(n0), .v(v0)
    );

    alu_seq #(.WIDTH(8), .SINGLE_CYCLE_SHIFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .s(s), .out_valid(out_valid1), .out_ready(out_ready1),
        .d(d1), .z(z1), .cout(c1), .n(n1), .v(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_result(input string who, input exp_t e, input logic [7:0] dd,
                              input logic zz, input logic cc, input logic nn, input logic vv);
        chk({who, ".d"}, 32'(dd), 32'(e.d));
        chk({who, ".z"}, 32'(zz), 32'(e.z));
        chk({who, ".cout"}, 32'(cc), 32'(e.c));
        chk({who, ".n"}, 32'(nn), 32'(e.n));
        chk({who, ".v"}, 32'(vv), 32'(e.v));
        if (e.cyc >= 0) chk({who, ".latency_cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    // Monitors: pop an expectation on every accepted result.
    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0.unexpected_result: got d=%0h required no output", d0);
            end else begin
                chk_result("dut0", q0.pop_front(), d0, z0, c0, n0, v0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1.unexpected_result: got d=%0h required no output", d1);
            end else begin
                chk_result("dut1", q1.pop_front(), d1, z1, c1, n1, v1);
            end
        end
    end

    // Issue one op on DUT sel; lat is the number of edges after accept until out_valid (-1: unchecked).
    task automatic issue(input int sel, input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input logic [7:0] ed, input logic ez, input logic ec,
                         input logic en, input logic ev, input int lat, input bit push);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!((sel == 0) ? in_ready0 : in_ready1) && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("issue_wait_in_ready", 32'(w >= 60), 32'd0);
        s = op; a = ia; b = ib; cin = ic;
        if (sel == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        e.d = ed; e.z = ez; e.c = ec; e.n = en; e.v = ev;
        e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
        if (push) begin
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(w >= 100), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; s = 4'h0;
        #1 rst_n = 1'b0;
        #7;
        chk("reset.in_ready", 32'(in_ready0), 32'd1);
        chk("reset.out_valid", 32'(out_valid0), 32'd0);
        chk("reset.d", 32'(d0), 32'd0);
        chk("reset.flags", 32'({z0, c0, n0, v0}), 32'd0);
        #14 rst_n = 1'b1;

        // Arithmetic and logic: {d, z, cout, n, v}
        issue(0, 4'b0000, 8'hF0, 8'h20, 1'b0, 8'h10, 0, 1, 0, 0, 0, 1);
        issue(0, 4'b0001, 8'h80, 8'h01, 1'b0, 8'h7F, 0, 1, 0, 1, 0, 1);
        issue(0, 4'b0110, 8'h5A, 8'h5A, 1'b0, 8'h00, 1, 0, 0, 0, 0, 1);
        issue(0, 4'b0010, 8'h7F, 8'h00, 1'b0, 8'h80, 0, 0, 1, 1, 0, 1);
        issue(0, 4'b0011, 8'h00, 8'h00, 1'b0, 8'hFF, 0, 0, 1, 0, 0, 1);
        issue(0, 4'b0011, 8'h80, 8'h00, 1'b0, 8'h7F, 0, 1, 0, 1, 0, 1);
        issue(0, 4'b0111, 8'h0F, 8'h00, 1'b1, 8'hF0, 0, 0, 1, 0, 0, 1);
        issue(0, 4'b0000, 8'h7F, 8'h00, 1'b1, 8'h80, 0, 0, 1, 1, 0, 1);
        issue(0, 4'b0100, 8'hF0, 8'h3C, 1'b1, 8'h30, 0, 0, 0, 0, 0, 1);

        // Shifts: multi-cycle on dut0, barrel on dut1
        issue(0, 4'b1101, 8'h90, 8'h03, 1'b0, 8'hF2, 0, 0, 1, 0, 3, 1);
        issue(1, 4'b1101, 8'h90, 8'h03, 1'b0, 8'hF2, 0, 0, 1, 0, 0, 1);
        issue(0, 4'b1010, 8'h81, 8'h00, 1'b0, 8'h81, 0, 0, 1, 0, 0, 1);
        issue(0, 4'b1010, 8'h81, 8'h01, 1'b0, 8'h03, 0, 1, 0, 0, 1, 1);
        issue(0, 4'b1001, 8'h01, 8'h02, 1'b1, 8'h07, 0, 0, 0, 0, 2, 1);
        issue(0, 4'b1100, 8'h81, 8'h01, 1'b0, 8'h40, 0, 1, 0, 0, 1, 1);
        issue(0, 4'b1111, 8'h00, 8'h04, 1'b1, 8'hF0, 0, 0, 1, 0, 4, 1);
        issue(0, 4'b1110, 8'h01, 8'h01, 1'b0, 8'h80, 0, 1, 1, 0, 1, 1);
        issue(0, 4'b1000, 8'h81, 8'h07, 1'b0, 8'h80, 0, 0, 1, 0, 7, 1);
        issue(1, 4'b1110, 8'h01, 8'h01, 1'b0, 8'h80, 0, 1, 1, 0, 0, 1);
        issue(1, 4'b1011, 8'hC3, 8'h02, 1'b0, 8'h0C, 0, 1, 0, 0, 0, 1);
        drain();

        // Back-pressure: result held while new operands are offered and ignored
        out_ready0 = 1'b0;
        issue(0, 4'b0000, 8'h01, 8'h02, 1'b0, 8'h03, 0, 0, 0, 0, -1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s = 4'b0000; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            in_valid0 = 1'b1;
            chk("hold.out_valid", 32'(out_valid0), 32'd1);
            chk("hold.in_ready", 32'(in_ready0), 32'd0);
            chk("hold.d", 32'(d0), 32'h03);
            chk("hold.flags", 32'({z0, c0, n0, v0}), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release.out_valid", 32'(out_valid0), 32'd0);
        chk("release.in_ready", 32'(in_ready0), 32'd1);
        chk("release.no_pending", 32'(q0.size()), 32'd0);

        // Reset in the middle of a 7-step shift drops the result
        issue(0, 4'b1000, 8'hFF, 8'h07, 1'b0, 8'h00, 0, 0, 0, 0, -1, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready0), 32'd1);
        chk("abort.out_valid", 32'(out_valid0), 32'd0);
        chk("abort.d", 32'(d0), 32'd0);
        chk("abort.flags", 32'({z0, c0, n0, v0}), 32'd0);
        #1 rst_n = 1'b1;
        issue(0, 4'b0000, 8'h01, 8'h01, 1'b0, 8'h02, 0, 0, 0, 0, 0, 1);
        drain();
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
